// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle handshaked ALU.
// Holds the opcode map, the legal-opcode bound, opcode class helpers
// and the controller state encoding.
package alu_pkg;

    // Opcode map
    localparam logic [3:0] SEQ   = 4'd0;
    localparam logic [3:0] XNOR  = 4'd1;
    localparam logic [3:0] NAND  = 4'd2;
    localparam logic [3:0] AND   = 4'd3;
    localparam logic [3:0] SLT   = 4'd4;
    localparam logic [3:0] PASSB = 4'd5;
    localparam logic [3:0] ADD   = 4'd6;
    localparam logic [3:0] MUL   = 4'd7;
    localparam logic [3:0] SLTU  = 4'd8;

    // Every opcode above this one is illegal
    localparam logic [3:0] LAST_LEGAL_OP = SLTU;

    // Controller states
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] MUL_BUSY = 2'd1;
    localparam logic [1:0] HOLD     = 2'd2;

    function automatic logic is_mul(input logic [3:0] op);
        return op == MUL;
    endfunction

    function automatic logic is_illegal(input logic [3:0] op);
        return op > LAST_LEGAL_OP;
    endfunction

endpackage

// File: rtl/alu_mc_handshake_if.sv
// Operand/result bus of the multi-cycle ALU.
//   opcode, input1, input2, in_valid : operation request (producer -> ALU)
//   in_ready                         : ALU accepts the request this cycle
//   result, carryFlag, zeroFlag,
//   errFlag, out_valid               : registered response (ALU -> consumer)
//   out_ready                        : consumer takes the response
// master = issue/writeback side, slave = the ALU.
interface alu_mc_handshake_if #(
    parameter int WIDTH = 8
);
    logic [3:0]       opcode;
    logic [WIDTH-1:0] input1;
    logic [WIDTH-1:0] input2;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] result;
    logic             carryFlag;
    logic             zeroFlag;
    logic             errFlag;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output opcode, input1, input2, in_valid, out_ready,
        input  in_ready, result, carryFlag, zeroFlag, errFlag, out_valid
    );

    modport slave (
        input  opcode, input1, input2, in_valid, out_ready,
        output in_ready, result, carryFlag, zeroFlag, errFlag, out_valid
    );
endinterface

// File: rtl/alu_shift_add_mul.sv
// Iterative shift-add multiplier, one partial product per clock.
//   clk, rst : clock, synchronous active-high reset
//   start    : load a/b and begin WIDTH iterations
//   a, b     : operands, captured on start
//   done     : high in the cycle whose clock edge completes the last step
//   product  : full 2*WIDTH product; valid together with done
module alu_shift_add_mul
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0]   a_q, a_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH:0]     partial;
    logic [2*WIDTH-1:0] step;

    // acc = {partial product, remaining multiplier bits}. Each step adds the
    // multiplicand to the upper half when the current multiplier LSB is set,
    // then shifts right, keeping the add's carry as the new top bit.
    always_comb begin
        partial = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
        step    = {partial, acc_q[WIDTH-1:1]};

        a_d   = a_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (start) begin
            a_d   = a;
            acc_d = {{WIDTH{1'b0}}, b};
            cnt_d = CNT_W'(WIDTH);
        end else if (cnt_q != '0) begin
            acc_d = step;
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // The final step's result is exposed combinationally so the owner can
    // register it on the same edge the counter reaches zero.
    assign done    = (cnt_q == CNT_W'(1));
    assign product = step;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            a_q   <= a_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/alu_mc_handshake.sv
// Registered ALU with valid/ready handshakes and an iterative multiplier.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of alu_mc_handshake_if (request in, response out)
// Non-MUL ops answer one edge after acceptance; MUL answers WIDTH edges
// after acceptance. The response is held until the consumer takes it.
module alu_mc_handshake
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic               clk,
    input logic               rst,
    alu_mc_handshake_if.slave bus
);
    logic [1:0]         state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               carry_q, carry_d;
    logic               zero_q, zero_d;
    logic               err_q, err_d;
    logic               out_valid_q, out_valid_d;

    logic               in_ready;
    logic               accept;
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH-1:0]   op_res;
    logic               op_carry;

    assign in_ready = !rst && ((state_q == IDLE) || (state_q == HOLD && bus.out_ready));
    assign accept   = bus.in_valid && in_ready;

    alu_shift_add_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (bus.input1),
        .b       (bus.input2),
        .done    (mul_done),
        .product (mul_product)
    );

    // Single-cycle operations
    always_comb begin
        add_sum  = {1'b0, bus.input1} + {1'b0, bus.input2};
        op_res   = '0;
        op_carry = 1'b0;
        case (bus.opcode)
            SEQ:   op_res = {{(WIDTH-1){1'b0}}, bus.input1 == bus.input2};
            XNOR:  op_res = ~(bus.input1 ^ bus.input2);
            NAND:  op_res = ~(bus.input1 & bus.input2);
            AND:   op_res = bus.input1 & bus.input2;
            SLT:   op_res = {{(WIDTH-1){1'b0}}, $signed(bus.input1) < $signed(bus.input2)};
            PASSB: op_res = bus.input2;
            ADD: begin
                op_res   = add_sum[WIDTH-1:0];
                op_carry = add_sum[WIDTH];
            end
            SLTU:  op_res = {{(WIDTH-1){1'b0}}, bus.input1 < bus.input2};
            default: op_res = '0;
        endcase
    end

    // Controller and output registers. An accept in HOLD takes priority over
    // the plain HOLD->IDLE exit so back-to-back operations have no bubble.
    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        carry_d     = carry_q;
        zero_d      = zero_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;
        mul_start   = 1'b0;

        if (accept) begin
            if (is_mul(bus.opcode)) begin
                mul_start   = 1'b1;
                out_valid_d = 1'b0;
                state_d     = MUL_BUSY;
            end else begin
                result_d    = op_res;
                carry_d     = op_carry;
                zero_d      = (op_res == '0);
                err_d       = is_illegal(bus.opcode);
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end
        end else if (state_q == HOLD && bus.out_ready) begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
        end else if (state_q == MUL_BUSY && mul_done) begin
            result_d    = mul_product[WIDTH-1:0];
            carry_d     = |mul_product[2*WIDTH-1:WIDTH];
            zero_d      = (mul_product[WIDTH-1:0] == '0);
            err_d       = 1'b0;
            out_valid_d = 1'b1;
            state_d     = HOLD;
        end else if (state_q != IDLE && state_q != MUL_BUSY && state_q != HOLD) begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            result_q    <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.result    = result_q;
    assign bus.carryFlag = carry_q;
    assign bus.zeroFlag  = zero_q;
    assign bus.errFlag   = err_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_alu_mc_handshake.sv
// Scoreboard bench for alu_mc_handshake (WIDTH=8): accepted requests push an
// expected response computed from the opcode rules; a negedge monitor
// compares handshake signals every cycle and response contents while valid.
module tb_alu_mc_handshake;
    localparam int W = 8;

    typedef struct {
        int res;
        int c;
        int z;
        int e;
        int due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   checking = 1'b0;
    bit   rst_prev = 1'b0;
    bit   rand_ordy = 1'b0;
    exp_t q[$];

    alu_mc_handshake_if #(.WIDTH(W)) bus ();

    alu_mc_handshake #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: results from the opcode rules with integer arithmetic.
    function automatic exp_t model(input int op, input int a, input int b);
        exp_t r;
        int   m = (1 << W) - 1;
        int   sa = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
        int   sb = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
        int   full;
        r.res = 0;
        r.c   = 0;
        r.e   = 0;
        r.due = 0;
        case (op)
            0: r.res = (a == b) ? 1 : 0;
            1: r.res = ~(a ^ b) & m;
            2: r.res = ~(a & b) & m;
            3: r.res = a & b;
            4: r.res = (sa < sb) ? 1 : 0;
            5: r.res = b;
            6: begin
                full  = a + b;
                r.res = full % (1 << W);
                r.c   = (full >= (1 << W)) ? 1 : 0;
            end
            7: begin
                full  = a * b;
                r.res = full % (1 << W);
                r.c   = (full >= (1 << W)) ? 1 : 0;
            end
            8: r.res = (a < b) ? 1 : 0;
            default: r.e = 1;
        endcase
        r.z = (r.res == 0) ? 1 : 0;
        return r;
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin
        bit   have;
        bit   exp_ir;
        exp_t e;
        if (checking) begin
            have   = (q.size() > 0) && (cyc >= q[0].due);
            exp_ir = rst ? 1'b0 : ((q.size() == 0) ? 1'b1 : (have ? bus.out_ready : 1'b0));
            chk("in_ready", 32'(bus.in_ready), 32'(exp_ir));
            chk("out_valid", 32'(bus.out_valid), 32'(have));
            if (have && bus.out_valid === 1'b1) begin
                chk("result", 32'(bus.result), 32'(q[0].res));
                chk("carryFlag", 32'(bus.carryFlag), 32'(q[0].c));
                chk("zeroFlag", 32'(bus.zeroFlag), 32'(q[0].z));
                chk("errFlag", 32'(bus.errFlag), 32'(q[0].e));
            end
            if (rst_prev) begin
                chk("rst_result", 32'(bus.result), 32'd0);
                chk("rst_flags", {29'd0, bus.carryFlag, bus.zeroFlag, bus.errFlag}, 32'd0);
            end
            if (rst) begin
                q.delete();
            end else begin
                if (have && bus.out_ready) void'(q.pop_front());
                if (bus.in_valid && exp_ir) begin
                    e = model(int'(bus.opcode), int'(bus.input1), int'(bus.input2));
                    e.due = cyc + 1 + ((bus.opcode == 4'd7) ? W : 0);
                    q.push_back(e);
                end
            end
            rst_prev = rst;
        end
    end

    // Random consumer back-pressure
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ordy) bus.out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bit ok = 1'b0;
        bus.opcode   = op;
        bus.input1   = a;
        bus.input2   = b;
        bus.in_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1 within 200 cycles (op %0d)", op);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.opcode   = 4'($urandom);
        bus.input1   = W'($urandom);
        bus.input2   = W'($urandom);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [3:0] op;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.opcode    = '0;
        bus.input1    = '0;
        bus.input2    = '0;
        rst = 1'b1;
        idle(2);
        checking = 1'b1;
        rst_prev = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(1);

        issue(4'd6, 8'hF0, 8'h20);      // ADD carry
        idle(2);
        issue(4'd7, 8'h10, 8'h11);      // MUL overflow
        idle(1);
        issue(4'd7, 8'h0F, 8'h03);      // MUL no overflow
        issue(4'd4, 8'h80, 8'h01);      // SLT signed
        issue(4'd8, 8'h80, 8'h01);      // SLTU
        issue(4'd0, 8'h5A, 8'h5A);      // SEQ equal
        idle(2);

        bus.out_ready = 1'b0;           // back-pressure, then back-to-back
        issue(4'd1, 8'hC3, 8'h5A);
        idle(3);
        bus.out_ready = 1'b1;
        issue(4'd5, 8'h12, 8'h77);
        idle(2);

        issue(4'd7, 8'hAB, 8'hCD);      // reset in the middle of a MUL
        idle(3);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(2);

        issue(4'hF, 8'h12, 8'h34);      // illegal, then legal clears errFlag
        issue(4'd3, 8'hF0, 8'h3C);
        issue(4'd2, 8'hFF, 8'hFF);
        idle(2);

        rand_ordy = 1'b1;
        for (int i = 0; i < 200; i++) begin
            op = ($urandom_range(0, 5) == 0) ? 4'd7 : 4'($urandom_range(0, 15));
            issue(op, W'($urandom), W'($urandom));
            idle($urandom_range(0, 2));
        end
        rand_ordy = 1'b0;
        bus.out_ready = 1'b1;
        idle(W + 4);
        chk("drain_empty", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: got no end of test expected finish before 500000 time units");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
